// File: rtl/rv32i_pkg.sv
// Shared types, opcodes and helpers for the rv32i_cpu single-cycle core.
// Optional trace output is enabled by defining RV32I_TRACE_EN.
package rv32i_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic     reg_we;
    imm_sel_e imm_sel;
    alu_op_e  alu_op;
    logic     a_pc;
    logic     b_imm;
    logic     is_load;
    logic     is_store;
    logic     is_branch;
    logic     is_jal;
    logic     is_jalr;
    logic     is_lui;
    logic     halt;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(
    input logic [31:0] i,
    input imm_sel_e    sel
  );
    logic [31:0] r;
    unique case (sel)
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: r = {{20{i[31]}}, i[31:20]};
    endcase
    return r;
  endfunction

  // bit 30 selects SUB only for register-register ops
  function automatic alu_op_e alu_dec(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_op
  );
    alu_op_e r;
    unique case (f3)
      3'b000: r = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu(
    input alu_op_e     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    unique case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << sh;
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = 32'($signed(a) >>> sh);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic r;
    unique case (f3)
      3'b000: r = (a == b);
      3'b001: r = (a != b);
      3'b100: r = ($signed(a) < $signed(b));
      3'b101: r = ($signed(a) >= $signed(b));
      3'b110: r = (a < b);
      3'b111: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_cpu_byte_mem.sv
// Byte-addressed little-endian memory: 32-bit combinational read,
// byte-strobed write; addresses wrap modulo MEM_BYTES.
module byte_mem #(
  parameter int MEM_BYTES = 65536,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [7:0] mem [0:MEM_BYTES-1];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++)
      rdata[8*i +: 8] = mem[raddr + AW'(i)];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i])
        mem[waddr + AW'(i)] <= wdata[8*i +: 8];
  end

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with private instruction/data memories.
// Define RV32I_TRACE_EN for a per-instruction retirement trace.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [31:0] pc;
  logic        halted;
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  ctrl_t       ctrl;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic [31:0] ld_word;
  logic [31:0] ld_val;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wb_en;
  logic        unused_bits;

  byte_mem #(.MEM_BYTES(MEM_BYTES)) im (
    .clk   (clk),
    .raddr (pc[AW-1:0]),
    .rdata (instr),
    .we    (1'b0),
    .wstrb (4'b0),
    .waddr ('0),
    .wdata (32'b0)
  );

  byte_mem #(.MEM_BYTES(MEM_BYTES)) dm (
    .clk   (clk),
    .raddr (alu_y[AW-1:0]),
    .rdata (ld_word),
    .we    (ctrl.is_store && !halted),
    .wstrb (wstrb),
    .waddr (alu_y[AW-1:0]),
    .wdata (rs2_val)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    ctrl         = '0;
    ctrl.imm_sel = IMM_I;
    ctrl.alu_op  = ALU_ADD;
    ctrl.b_imm   = 1'b1;
    unique case (1'b1)
      (opcode == LUI): begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = IMM_U;
        ctrl.is_lui  = 1'b1;
      end
      (opcode == AUIPC): begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = IMM_U;
        ctrl.a_pc    = 1'b1;
      end
      (opcode == JAL): begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = IMM_J;
        ctrl.is_jal  = 1'b1;
      end
      (opcode == JALR): begin
        ctrl.reg_we  = 1'b1;
        ctrl.is_jalr = 1'b1;
      end
      (opcode == BRANCH): begin
        ctrl.imm_sel   = IMM_B;
        ctrl.is_branch = 1'b1;
      end
      (opcode == LOAD): begin
        ctrl.reg_we  = 1'b1;
        ctrl.is_load = 1'b1;
      end
      (opcode == STORE): begin
        ctrl.imm_sel  = IMM_S;
        ctrl.is_store = 1'b1;
      end
      (opcode == OP_IMM): begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_dec(f3, instr[30], 1'b0);
      end
      (opcode == OP): begin
        ctrl.reg_we = 1'b1;
        ctrl.b_imm  = 1'b0;
        ctrl.alu_op = alu_dec(f3, instr[30], 1'b1);
      end
      // ECALL/EBREAK only; other SYSTEM encodings act as NOP
      (opcode == SYSTEM): begin
        ctrl.halt = (f3 == 3'b000) && (rs1 == 5'd0) &&
                    (rd == 5'd0) &&
                    (instr[31:21] == 11'd0);
      end
      default: ;
    endcase
  end

  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign imm     = gen_imm(instr, ctrl.imm_sel);
  assign alu_a   = ctrl.a_pc ? pc : rs1_val;
  assign alu_b   = ctrl.b_imm ? imm : rs2_val;
  assign alu_y   = alu(ctrl.alu_op, alu_a, alu_b);
  assign pc4     = pc + 32'd4;

  always_comb begin
    next_pc = pc4;
    if (ctrl.is_jal)
      next_pc = pc + imm;
    else if (ctrl.is_jalr)
      next_pc = alu_y & ~32'd1;
    else if (ctrl.is_branch && br_taken(f3, rs1_val, rs2_val))
      next_pc = pc + imm;
  end

  always_comb begin
    unique case (f3)
      3'b000: ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001: ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100: ld_val = {24'b0, ld_word[7:0]};
      3'b101: ld_val = {16'b0, ld_word[15:0]};
      default: ld_val = ld_word;
    endcase
  end

  always_comb begin
    unique case (f3[1:0])
      2'b00: wstrb = 4'b0001;
      2'b01: wstrb = 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  always_comb begin
    wdata = alu_y;
    if (ctrl.is_lui)
      wdata = imm;
    else if (ctrl.is_jal || ctrl.is_jalr)
      wdata = pc4;
    else if (ctrl.is_load)
      wdata = ld_val;
  end

  assign wb_en = ctrl.reg_we && (rd != 5'd0) && !halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (!halted) begin
      if (ctrl.halt)
        halted <= 1'b1;
      else
        pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_en) begin
      regs[rd] <= wdata;
    end
  end

  assign unused_bits = ^{pc[31:AW], instr[31],
                         instr[29:25]};

`ifdef RV32I_TRACE_EN
  always @(posedge clk) begin
    if (rst && !halted)
      $display("pc=%08h instr=%08h rd=x%0d wdata=%08h",
               pc, instr,
               wb_en ? rd : 5'd0,
               wb_en ? wdata : 32'd0);
  end
`endif

endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed program test for rv32i_cpu: ALU, loads/stores, branches,
// jumps, x0, halt and asynchronous mid-program reset.
module tb_rv32i_cpu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rv32i_cpu dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] O_OP  = 7'b0110011;
  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e_i(int imm, int rs1, int f3,
                                      int rd, logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_r(int f7, int rs2, int rs1,
                                      int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), O_OP};
  endfunction

  function automatic logic [31:0] e_s(int imm, int rs2, int rs1,
                                      int f3);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], O_ST};
  endfunction

  function automatic logic [31:0] e_b(int imm, int rs2, int rs1,
                                      int f3);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] e_u(int imm, int rd,
                                      logic [6:0] op);
    logic [19:0] im;
    im = imm[19:0];
    return {im, 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_j(int imm, int rd);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd),
            7'b1101111};
  endfunction

  task automatic put(input logic [15:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      dut.im.mem[a + 16'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] dm_word(input logic [15:0] a);
    return {dut.dm.mem[a + 16'd3], dut.dm.mem[a + 16'd2],
            dut.dm.mem[a + 16'd1], dut.dm.mem[a]};
  endfunction

  task automatic load_program();
    put(16'h000, e_i(-5, 0, 0, 1, O_IMM));
    put(16'h004, e_i(12'h401, 1, 5, 2, O_IMM));
    put(16'h008, e_r(0, 1, 0, 3, 3));
    put(16'h00C, e_u(20'h80FF8, 5, 7'b0110111));
    put(16'h010, e_i(-255, 5, 0, 5, O_IMM));
    put(16'h014, e_u(20'h00009, 6, 7'b0110111));
    put(16'h018, e_s(0, 5, 6, 2));
    put(16'h01C, e_i(0, 6, 0, 7, O_LD));
    put(16'h020, e_i(0, 6, 4, 8, O_LD));
    put(16'h024, e_i(0, 6, 1, 9, O_LD));
    put(16'h028, e_i(0, 6, 5, 10, O_LD));
    put(16'h02C, e_i(2, 6, 1, 11, O_LD));
    put(16'h030, e_i(2, 6, 5, 12, O_LD));
    put(16'h034, e_i(171, 0, 0, 13, O_IMM));
    put(16'h038, e_s(1, 13, 6, 0));
    put(16'h03C, e_i(1, 0, 0, 14, O_IMM));
    put(16'h040, e_b(8, 14, 1, 4));
    put(16'h044, e_i(99, 0, 0, 15, O_IMM));
    put(16'h048, e_b(8, 14, 1, 7));
    put(16'h04C, e_i(77, 0, 0, 15, O_IMM));
    put(16'h050, e_j(8, 16));
    put(16'h054, e_i(55, 0, 0, 15, O_IMM));
    put(16'h058, e_i(5, 0, 0, 0, O_IMM));
    put(16'h05C, e_r(0, 0, 0, 0, 4));
    put(16'h060, e_i(257, 0, 0, 17, O_IMM));
    put(16'h064, e_i(0, 17, 0, 18, 7'b1100111));
    put(16'h068, e_i(66, 0, 0, 15, O_IMM));
    put(16'h100, e_r(32, 1, 14, 0, 21));
    put(16'h104, e_r(0, 21, 14, 1, 22));
    put(16'h108, e_r(0, 14, 1, 5, 23));
    put(16'h10C, e_r(0, 1, 5, 4, 24));
    put(16'h110, e_r(0, 14, 1, 2, 25));
    put(16'h114, e_u(1, 26, 7'b0010111));
    put(16'h118, 32'h0000000F);
    put(16'h11C, 32'h00000000);
    put(16'h120, e_s(4, 1, 6, 2));
    put(16'h124, e_s(8, 2, 6, 2));
    put(16'h128, e_s(12, 16, 6, 2));
    put(16'h12C, e_s(16, 24, 6, 2));
    put(16'h130, e_i(255, 0, 0, 19, O_IMM));
    put(16'h134, e_u(20'h00010, 20, 7'b0110111));
    put(16'h138, e_s(-4, 19, 20, 0));
    put(16'h13C, 32'h00000073);
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (dut.dm.mem[16'hFFFC] !== 8'hFF && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {24'b0, dut.dm.mem[16'hFFFC]}, 32'h000000FF);
  endtask

  int          ridx [$];
  logic [31:0] rexp [$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    load_program();
    dut.dm.mem[16'hFFFC] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_halted", {31'b0, dut.halted}, 32'h0);
    check("reset_x1", dut.regs[1], 32'h0);
    rst = 1'b1;

    run_to_done("done_first");
    repeat (3) @(negedge clk);
    check("halted", {31'b0, dut.halted}, 32'h1);
    check("halt_pc", dut.pc, 32'h0000013C);

    ridx = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
             14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24,
             25, 26, 0};
    rexp = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'h1, 32'h0,
             32'h80FF7F01, 32'h9000, 32'h1, 32'h1,
             32'h7F01, 32'h7F01, 32'hFFFF80FF, 32'h80FF,
             32'hAB, 32'h1, 32'h0, 32'h54, 32'h101, 32'h68,
             32'hFF, 32'h10000, 32'h6, 32'h40, 32'h7FFFFFFD,
             32'h7F0080FA, 32'h1, 32'h1114, 32'h0};
    foreach (ridx[i])
      check($sformatf("x%0d", ridx[i]), dut.regs[ridx[i]],
            rexp[i]);

    check("mem_9000", dm_word(16'h9000), 32'h80FFAB01);
    check("mem_9004", dm_word(16'h9004), 32'hFFFFFFFB);
    check("mem_9008", dm_word(16'h9008), 32'hFFFFFFFD);
    check("mem_900c", dm_word(16'h900C), 32'h00000054);
    check("mem_9010", dm_word(16'h9010), 32'h7F0080FA);

    // restart: run a few instructions, then reset between edges
    rst = 1'b0;
    @(negedge clk);
    dut.dm.mem[16'hFFFC] = 8'h00;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_pc_nonzero", {31'b0, dut.pc != 32'h0}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_pc", dut.pc, 32'h0);
    check("async_x1", dut.regs[1], 32'h0);
    check("async_halted", {31'b0, dut.halted}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_to_done("done_second");
    repeat (2) @(negedge clk);
    check("rerun_x26", dut.regs[26], 32'h1114);
    check("rerun_9000", dm_word(16'h9000), 32'h80FFAB01);
    check("rerun_pc", dut.pc, 32'h0000013C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
